// File: rtl/lockable_reg_bank_pkg.sv
// Shared types and constants for the lockable register bank.
package lockable_reg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } glock_state_t;

  localparam logic [7:0] DEFAULT_LOCK_KEY = 8'hA5;

endpackage

// File: rtl/lockable_reg_bank_glock_fsm.sv
// Global-lock arm/confirm state machine with a timeout window; LOCKED is
// terminal until reset.
module glock_fsm
  import lockable_reg_pkg::*;
#(
  parameter int              DATA_W       = 8,
  parameter logic [DATA_W-1:0] LOCK_KEY   = DATA_W'(DEFAULT_LOCK_KEY),
  parameter int              LOCK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_arm,
  input  logic              i_confirm,
  input  logic [DATA_W-1:0] i_key,
  output logic              o_armed,
  output logic              o_global_locked,
  output logic              o_glock_fail
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);

  glock_state_t     r_state;
  glock_state_t     w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_fail;
  logic             w_fail_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_fail  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fail  <= w_fail_nxt;
    end
  end

  // A confirm wins over a re-arm, and a re-arm wins over an expiring window.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fail_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_arm) begin
          w_state_nxt = ARMED;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      ARMED: begin
        if (i_confirm) begin
          if (i_key == LOCK_KEY) begin
            w_state_nxt = LOCKED;
          end else begin
            w_state_nxt = IDLE;
            w_fail_nxt  = 1'b1;
          end
        end else if (i_arm) begin
          w_cnt_nxt = CNT_LOAD;
        end else if (r_cnt == '0) begin
          w_state_nxt = IDLE;
          w_fail_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      LOCKED: begin
        w_state_nxt = LOCKED;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_armed         = (r_state == ARMED);
  assign o_global_locked = (r_state == LOCKED);
  assign o_glock_fail    = r_fail;

endmodule

// File: rtl/lockable_reg_bank.sv
// Bank of registers with sticky per-register write locks and a key-protected
// global lock; every write/lock request gets a one-cycle ack with error flag.
module lockable_reg_bank
  import lockable_reg_pkg::*;
#(
  parameter int                NUM_REGS     = 8,
  parameter int                DATA_W       = 8,
  parameter int                ADDR_W       = $clog2(NUM_REGS),
  parameter logic [DATA_W-1:0] RESET_VAL    = '0,
  parameter logic [DATA_W-1:0] LOCK_KEY     = DATA_W'(DEFAULT_LOCK_KEY),
  parameter int                LOCK_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                lock_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                wr_ack,
  output logic                wr_err,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic [NUM_REGS-1:0] lock_status,
  input  logic                glock_arm,
  input  logic                glock_confirm,
  output logic                glock_fail,
  output logic                global_locked
);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_lock;
  logic                r_ack;
  logic                r_err;
  logic [DATA_W-1:0]   r_rd_data;

  logic w_wr_in_range;
  logic w_rd_in_range;
  logic w_armed;
  logic w_global_locked;
  logic w_consumed;
  logic w_req;
  logic w_wr_ok;
  logic w_lock_ok;
  logic w_err;
  logic w_do_wr;
  logic w_do_lock;

  generate
    if (NUM_REGS == (1 << ADDR_W)) begin : g_full_range
      assign w_wr_in_range = 1'b1;
      assign w_rd_in_range = 1'b1;
    end else begin : g_part_range
      assign w_wr_in_range = (int'(wr_addr) < NUM_REGS);
      assign w_rd_in_range = (int'(rd_addr) < NUM_REGS);
    end
  endgenerate

  glock_fsm #(
    .DATA_W       (DATA_W),
    .LOCK_KEY     (LOCK_KEY),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) u_glock_fsm (
    .clk             (clk),
    .rst             (rst),
    .i_arm           (glock_arm),
    .i_confirm       (glock_confirm),
    .i_key           (wr_data),
    .o_armed         (w_armed),
    .o_global_locked (w_global_locked),
    .o_glock_fail    (glock_fail)
  );

  // A confirm while armed owns wr_data, so any write/lock that cycle is dropped.
  assign w_consumed = w_armed & glock_confirm;
  assign w_req      = (wr_en | lock_en) & ~w_consumed;
  assign w_wr_ok    = wr_en & w_wr_in_range & ~r_lock[wr_addr] & ~w_global_locked;
  assign w_lock_ok  = lock_en & w_wr_in_range & ~w_global_locked;
  assign w_err      = (wr_en & ~w_wr_ok) | (lock_en & ~w_lock_ok);
  assign w_do_wr    = w_wr_ok & ~w_consumed;
  assign w_do_lock  = w_lock_ok & ~w_consumed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
    end else if (w_do_wr) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock    <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      if (w_do_lock) r_lock[wr_addr] <= 1'b1;
      r_ack     <= w_req;
      r_err     <= w_req & w_err;
      r_rd_data <= w_rd_in_range ? r_regs[rd_addr] : '0;
    end
  end

  assign wr_ack        = r_ack;
  assign wr_err        = r_err;
  assign rd_data       = r_rd_data;
  assign lock_status   = r_lock;
  assign global_locked = w_global_locked;

endmodule

// File: tb/tb_lockable_reg_bank.sv
// Directed bench for lockable_reg_bank (6 registers) with an ack scoreboard.
module tb_lockable_reg_bank;

  localparam int NR = 6;
  localparam int TO = 16;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic          lock_en;
  logic [2:0]    wr_addr;
  logic [7:0]    wr_data;
  logic          wr_ack;
  logic          wr_err;
  logic [2:0]    rd_addr;
  logic [7:0]    rd_data;
  logic [NR-1:0] lock_status;
  logic          glock_arm;
  logic          glock_confirm;
  logic          glock_fail;
  logic          global_locked;

  int n_checks = 0;
  int n_err    = 0;

  logic          exp_q [$];
  logic [7:0]    mdl_regs [NR];
  logic [NR-1:0] mdl_lock;
  logic          mdl_gl;

  lockable_reg_bank #(
    .NUM_REGS     (NR),
    .DATA_W       (8),
    .RESET_VAL    (8'h00),
    .LOCK_KEY     (8'hA5),
    .LOCK_TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .lock_en       (lock_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ack        (wr_ack),
    .wr_err        (wr_err),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .lock_status   (lock_status),
    .glock_arm     (glock_arm),
    .glock_confirm (glock_confirm),
    .glock_fail    (glock_fail),
    .global_locked (global_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < NR; i++) mdl_regs[i] = 8'h00;
    mdl_lock = '0;
    mdl_gl   = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one write/lock request, predicting its ack error flag.
  task automatic req(input logic wr, input logic lk, input int addr, input logic [7:0] data);
    logic in_r, wok, lok;
    in_r = (addr < NR);
    wok  = 1'b0;
    lok  = 1'b0;
    if (in_r && !mdl_gl) begin
      wok = wr && !mdl_lock[addr];
      lok = lk;
    end
    if (wr || lk) exp_q.push_back((wr && !wok) || (lk && !lok));
    if (wok) mdl_regs[addr] = data;
    if (lok) mdl_lock[addr] = 1'b1;
    wr_en   = wr;
    lock_en = lk;
    wr_addr = 3'(addr);
    wr_data = data;
    step(1);
    wr_en   = 1'b0;
    lock_en = 1'b0;
  endtask

  task automatic rd_chk(input int addr, input string tag);
    logic [7:0] exp;
    exp = 8'h00;
    if (addr < NR) exp = mdl_regs[addr];
    rd_addr = 3'(addr);
    step(1);
    check(tag, rd_data, exp);
  endtask

  task automatic arm();
    glock_arm = 1'b1;
    step(1);
    glock_arm = 1'b0;
  endtask

  always @(negedge clk) begin
    if (wr_ack) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL ack_unexpected: observed=ack expected=no_ack");
      end
      if (exp_q.size() != 0) check("ack_err", wr_err, exp_q.pop_front());
    end
  end

  initial begin
    logic [7:0] old;
    rst = 1'b1; wr_en = 1'b0; lock_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; glock_arm = 1'b0; glock_confirm = 1'b0;
    mdl_reset();
    step(2);
    check("rst_ack", wr_ack, 0);
    check("rst_err", wr_err, 0);
    check("rst_rd", rd_data, 0);
    check("rst_lock", lock_status, 0);
    check("rst_gfail", glock_fail, 0);
    check("rst_glocked", global_locked, 0);
    rst = 1'b0;
    step(1);

    // Basic write and read back
    req(1, 0, 2, 8'h3C);
    rd_chk(2, "rd_reg2");
    check("rd_reg2_const", rd_data, 8'h3C);

    // Write-and-lock, then back-to-back write to the same register
    req(1, 1, 5, 8'h11);
    req(1, 0, 5, 8'h22);
    check("lock5", lock_status, 6'b100000);
    rd_chk(5, "rd_reg5");
    check("rd_reg5_const", rd_data, 8'h11);
    req(1, 0, 4, 8'h44);
    rd_chk(4, "rd_reg4");

    // Lock alone, relock, write to locked register
    req(0, 1, 3, 8'h00);
    req(0, 1, 3, 8'h00);
    req(1, 0, 3, 8'h33);
    check("lock3", lock_status, 6'b101000);

    // Out of range write / lock / read
    req(1, 0, 7, 8'hEE);
    req(0, 1, 6, 8'h00);
    check("lock_oor", lock_status, 6'b101000);
    rd_chk(7, "rd_oor");
    for (int i = 0; i < NR; i++) rd_chk(i, $sformatf("rd_all%0d", i));

    // Read of the address being written returns the old value
    old = mdl_regs[2];
    rd_addr = 3'd2;
    req(1, 0, 2, 8'h99);
    check("rd_old", rd_data, old);
    rd_chk(2, "rd_new");

    // Wrong key: fail pulse, the concurrent write is dropped without ack
    arm();
    step(2);
    glock_confirm = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h5A;
    step(1);
    glock_confirm = 1'b0; wr_en = 1'b0;
    check("badkey_fail", glock_fail, 1);
    check("badkey_glocked", global_locked, 0);
    step(1);
    check("badkey_fail_pulse", glock_fail, 0);
    rd_chk(0, "rd_reg0_dropped");

    // Confirm in IDLE is ignored and does not block the write
    glock_confirm = 1'b1;
    req(1, 0, 4, 8'hA5);
    glock_confirm = 1'b0;
    check("idle_conf_fail", glock_fail, 0);
    check("idle_conf_glocked", global_locked, 0);
    rd_chk(4, "rd_reg4_idleconf");

    // Timeout: fail exactly LOCK_TIMEOUT edges after arm
    arm();
    for (int k = 1; k <= TO; k++) begin
      step(1);
      check($sformatf("timeout_k%0d", k), glock_fail, (k == TO));
    end
    check("timeout_glocked", global_locked, 0);
    step(1);
    check("timeout_pulse", glock_fail, 0);

    // Re-arm restarts the window
    arm();
    step(9);
    check("rearm_pre", glock_fail, 0);
    arm();
    for (int k = 1; k <= TO; k++) begin
      step(1);
      check($sformatf("rearm_k%0d", k), glock_fail, (k == TO));
    end

    // Successful global lock; writes continue while armed
    step(1);
    arm();
    req(1, 0, 1, 8'h05);
    step(1);
    glock_confirm = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hA5;
    step(1);
    glock_confirm = 1'b0; wr_en = 1'b0;
    mdl_gl = 1'b1;
    check("glock_on", global_locked, 1);
    check("glock_nofail", glock_fail, 0);
    req(1, 0, 0, 8'h77);
    req(0, 1, 0, 8'h00);
    check("glock_lockbits", lock_status, 6'b101000);
    rd_chk(0, "rd_reg0_glock");
    rd_chk(1, "rd_reg1_armed_wr");

    // Asynchronous reset clears the global lock mid-cycle
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    mdl_reset();
    check("arst_glocked", global_locked, 0);
    check("arst_lock", lock_status, 0);
    step(1);
    rst = 1'b0;

    // Lock reg 1, reset mid-window, everything clean afterwards
    req(0, 1, 1, 8'h00);
    check("lock1", lock_status, 6'b000010);
    arm();
    step(1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    mdl_reset();
    check("arst2_lock", lock_status, 0);
    check("arst2_rd", rd_data, 0);
    step(1);
    rst = 1'b0;
    for (int i = 0; i < NR; i++) rd_chk(i, $sformatf("rd_rst%0d", i));
    req(1, 0, 1, 8'h5C);
    rd_chk(1, "rd_reg1_after_rst");
    glock_confirm = 1'b1; wr_data = 8'hA5;
    step(1);
    glock_confirm = 1'b0;
    step(1);
    check("post_rst_idle", global_locked, 0);
    check("post_rst_nofail", glock_fail, 0);

    step(2);
    check("ack_missing", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/lockable_reg_bank.md
# lockable_reg_bank

Parametrised bank of NUM_REGS lockable registers, each DATA_W bits wide, with per-register sticky write locks and a key-protected global lock. It sits on the configuration write path between the bus-side register decoder and the security-relevant configuration it guards. Once a lock takes effect, only reset can clear it. Every write attempt returns a one-cycle acknowledge with an error flag.

## Interface
- NUM_REGS, 8, number of registers (≥2)
- DATA_W, 8, register width
- ADDR_W, $clog2(NUM_REGS), address width
- RESET_VAL, 0, reset value of every register
- LOCK_KEY, 'hA5 (DATA_W bits), value of wr_data that confirms the global lock
- LOCK_TIMEOUT, 16, number of cycles the global-lock arm window stays open (≥2)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write request
- lock_en  in  1  lock request for register wr_addr
- wr_addr  in  ADDR_W  target register
- wr_data  in  DATA_W  write data; also carries the key on glock_confirm
- wr_ack  out  1  one-cycle pulse responding to each wr_en or lock_en
- wr_err  out  1  valid with wr_ack; 1 = request rejected
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  registered read data
- lock_status  out  NUM_REGS  per-register lock bits
- glock_arm  in  1  opens the global-lock window
- glock_confirm  in  1  presents the key on wr_data
- glock_fail  out  1  one-cycle pulse on a wrong key or a timeout
- global_locked  out  1  entire bank locked

## Operation
- **Reset:** all registers = RESET_VAL; lock_status, wr_ack, wr_err, rd_data, glock_fail and global_locked = 0; FSM = IDLE.
- **Write accepted** when wr_en=1, wr_addr<NUM_REGS, lock_status[wr_addr]=0 and global_locked=0. The register updates and wr_ack=1, wr_err=0 on the next cycle.
- **Write rejected** in every other case (locked register, global lock, out-of-range address). The register is unchanged; wr_ack=1, wr_err=1.
- **lock_en=1 with wr_en=1 on an unlocked, in-range register:** write and lock in the same edge.
- **lock_en=1 alone:** locks register wr_addr and acks with wr_err=0. Relocking an already locked register is also acked with wr_err=0.
- **lock_en out of range, or while global_locked=1:** wr_err=1; no lock bit changes.
- **Stickiness:** lock bits are never cleared except by rst.
- **Global-lock FSM:**
  - IDLE → ARMED on glock_arm. The counter loads LOCK_TIMEOUT-1.
  - ARMED, glock_confirm with wr_data==LOCK_KEY → LOCKED.
  - ARMED, glock_confirm with the wrong key → IDLE, glock_fail pulse.
  - ARMED, counter reaches 0 without a confirm → IDLE, glock_fail pulse.
  - glock_arm while ARMED restarts the counter.
  - LOCKED is terminal until rst. global_locked=1 in LOCKED.
  - glock_confirm in IDLE or LOCKED is ignored; no pulse.
- **Priority:** glock_confirm in ARMED consumes wr_data, so wr_en/lock_en that cycle are dropped with no ack. Outside ARMED, glock_confirm has no effect on writes.
- Normal writes continue while the FSM is ARMED.
- **Read:** rd_data = reg[rd_addr] one cycle later. Out-of-range rd_addr returns 0. Reading the address being written in the same cycle returns the old value.

## Timing
- Write, lock and ack latency: 1 cycle. lock_status reflects a new lock one cycle after the request.
- A write in the cycle immediately after a lock request to the same address is rejected.
- Global lock takes effect on the confirm edge. A write in the same cycle as a successful confirm is dropped; writes from the next cycle onward are rejected.
- Timeout: with glock_arm at cycle t and no confirm, glock_fail pulses at cycle t+LOCK_TIMEOUT.
- rst asserted mid-window or mid-write clears all state immediately (asynchronous); nothing pending survives.

## Structure
- Package lockable_reg_pkg holds the glock_state_t enum (IDLE, ARMED, LOCKED) and the default key constant.
- Sub-module glock_fsm contains the arm/confirm/timeout state machine and counter. It outputs global_locked and glock_fail.
- The top level holds the register array, the lock bits, the ack/err logic and the read port.

## Test plan
- **Reset and basic write:** after rst, write 0x3C to reg 2 → wr_ack=1, wr_err=0; rd_addr=2 → rd_data=0x3C.
- **Write-and-lock:** wr_en+lock_en on reg 5 with 0x11, then write 0x22 to reg 5 → lock_status[5]=1, second ack has wr_err=1, rd_data stays 0x11; reg 4 is still writable.
- **Out-of-range write:** with NUM_REGS=6, write to address 7 → wr_err=1; no register changes.
- **Global lock success:** glock_arm, then glock_confirm with 0xA5 three cycles later → global_locked=1; write 0x77 to unlocked reg 0 → wr_err=1.
- **Global lock failures:** confirm with 0x5A → glock_fail pulse, FSM back to IDLE. Separately, arm and wait 16 cycles → glock_fail at t+16, global_locked=0.
- **Stickiness across reset:** lock reg 1, assert rst mid-ARMED → all locks clear, registers = RESET_VAL, FSM=IDLE, writes succeed afterwards.
